// File: rtl/bnn_accum_threshold.sv
// Accumulates per-PE popcounts over a first/last framed batch and binarizes each
// PE total against a programmable threshold; results leave on a valid/ready handshake.
module bnn_accum_threshold #(
  parameter int NUM_PES = 64,
  parameter int PCW     = 7,
  parameter int ACC_W   = 16,
  parameter int AW      = $clog2(NUM_PES)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ce,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_first,
  input  logic                   in_last,
  input  logic [NUM_PES*PCW-1:0] popcounts_in_flat,
  input  logic                   thr_we,
  input  logic [AW-1:0]          thr_addr,
  input  logic [ACC_W-1:0]       thr_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [NUM_PES-1:0]     out_bits,
  output logic [15:0]            out_chunks,
  output logic                   sat_flag,
  output logic                   proto_err
);

  localparam int SUM_W = ACC_W + 1;

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_ACC = 1'b1} state_t;

  state_t             state_r;
  state_t             state_next_s;
  logic [ACC_W-1:0]   acc_r [NUM_PES];
  logic [ACC_W-1:0]   thr_r [NUM_PES];
  logic [ACC_W-1:0]   sum_s [NUM_PES];
  logic [NUM_PES-1:0] ovf_s;
  logic [NUM_PES-1:0] cmp_s;
  logic [15:0]        chunks_r;
  logic [15:0]        chunks_next_s;
  logic               accept_s;
  logic               restart_s;
  logic               err_s;

  // Saturating add; MSB of the result flags that the clamp engaged.
  function automatic logic [SUM_W-1:0] sat_add(input logic [ACC_W-1:0] a,
                                               input logic [PCW-1:0]   b);
    logic [SUM_W-1:0] wide;
    wide = {1'b0, a} + SUM_W'(b);
    if (wide[ACC_W]) begin
      sat_add = {1'b1, {ACC_W{1'b1}}};
    end else begin
      sat_add = wide;
    end
  endfunction

  assign in_ready  = ce & (~out_valid | out_ready);
  assign accept_s  = in_valid & in_ready;
  // A non-first beat with no open frame is recovered by treating it as a first beat.
  assign restart_s = in_first | (state_r == S_IDLE);
  assign err_s     = accept_s & (in_first ? (state_r == S_ACC) : (state_r == S_IDLE));

  // Per-PE candidate sums and compares against the currently stored threshold
  always_comb begin
    logic [SUM_W-1:0] add_v;
    add_v = '0;
    for (int i = 0; i < NUM_PES; i++) begin
      add_v = sat_add(acc_r[i], popcounts_in_flat[i*PCW +: PCW]);
      if (restart_s) begin
        sum_s[i] = ACC_W'(popcounts_in_flat[i*PCW +: PCW]);
        ovf_s[i] = 1'b0;
      end else begin
        sum_s[i] = add_v[ACC_W-1:0];
        ovf_s[i] = add_v[ACC_W];
      end
      cmp_s[i] = (sum_s[i] >= thr_r[i]);
    end
    if (restart_s) begin
      chunks_next_s = 16'd1;
    end else if (chunks_r == 16'hFFFF) begin
      chunks_next_s = 16'hFFFF;
    end else begin
      chunks_next_s = chunks_r + 16'd1;
    end
  end

  // Frame state next-state logic
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      S_IDLE, S_ACC: begin
        if (accept_s) begin
          state_next_s = in_last ? S_IDLE : S_ACC;
        end else begin
          state_next_s = state_r;
        end
      end
      default: state_next_s = S_IDLE;
    endcase
  end

  // Frame state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
    end else if (ce) begin
      state_r <= state_next_s;
    end
  end

  // Threshold file, accumulators, result registers and sticky flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_PES; i++) begin
        acc_r[i] <= '0;
        thr_r[i] <= '0;
      end
      chunks_r   <= 16'd0;
      out_valid  <= 1'b0;
      out_bits   <= '0;
      out_chunks <= 16'd0;
      sat_flag   <= 1'b0;
      proto_err  <= 1'b0;
    end else if (ce) begin
      if (thr_we) begin
        thr_r[thr_addr] <= thr_data;
      end
      if (accept_s) begin
        for (int i = 0; i < NUM_PES; i++) begin
          acc_r[i] <= sum_s[i];
        end
        chunks_r <= chunks_next_s;
      end
      if (accept_s && in_last) begin
        out_valid  <= 1'b1;
        out_bits   <= cmp_s;
        out_chunks <= chunks_next_s;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      sat_flag  <= sat_flag | (accept_s & (|ovf_s));
      proto_err <= proto_err | err_s;
    end
  end

endmodule
